sample_capture_ctrl: RTL and testbench

Capture sequencer for the signal sampler. Takes the already-synchronized probe bus from the synchronizer chain and applies a programmable sample-rate divider. Writes samples into a circular sample RAM while armed, detects a masked level/edge trigger, then records a programmable number of post-trigger samples before reporting done. Sits between the synchronizer and the sample RAM; host/readout logic drives the config and reads status.

---
 rtl/sample_capture_ctrl_pkg.sv | 19 +
 rtl/sample_capture_ctrl_if.sv | 12 +
 rtl/sample_capture_ctrl_rate_div.sv | 32 +++
 rtl/sample_capture_ctrl.sv | 141 ++++++++++++++
 tb/tb_sample_capture_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_capture_ctrl_pkg.sv
// Shared definitions for the sampler capture path: FSM state encodings and
// small helpers used by the capture sequencer.
package sample_capture_ctrl_pkg;

   localparam int STATE_WIDTH = 2;

   typedef enum logic [STATE_WIDTH-1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } capture_state_e;

   // Samples are only taken while the capture is running.
   function automatic logic is_capturing(capture_state_e s);
      return (s == ST_ARMED) || (s == ST_POST);
   endfunction

endpackage

// File: rtl/sample_capture_ctrl_if.sv
// Write port toward the circular sample RAM.
interface sample_capture_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
);
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/sample_capture_ctrl_rate_div.sv
// Programmable sample-rate divider: one tick every reload+1 enabled cycles,
// with the first tick on the first enabled cycle after a clear.
module sample_rate_div #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] reload,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] count;

   assign tick = enable && (count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         if (count == '0) begin
            count <= reload;
         end else begin
            count <= count - DIV_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/sample_capture_ctrl.sv
// Capture sequencer: divides the probe stream, fills a circular sample RAM
// while armed, detects a masked level/edge trigger and records post-trigger samples.
module sample_capture_ctrl
   import sample_capture_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_WIDTH-1:0]  sample_in,
   input  logic                   arm,
   input  logic                   abort,
   input  logic [DATA_WIDTH-1:0]  trig_mask,
   input  logic [DATA_WIDTH-1:0]  trig_value,
   input  logic                   trig_edge,
   input  logic [DIV_WIDTH-1:0]   rate_div,
   input  logic [ADDR_WIDTH-1:0]  post_count,
   sample_capture_ctrl_if.master  ram,
   output logic [STATE_WIDTH-1:0] state,
   output logic [ADDR_WIDTH-1:0]  trig_addr,
   output logic                   wrapped,
   output logic                   done
);

   capture_state_e cur_state, nxt_state;

   logic [DATA_WIDTH-1:0] mask_q;
   logic [DATA_WIDTH-1:0] value_q;
   logic                  edge_q;
   logic [DIV_WIDTH-1:0]  div_q;
   logic [ADDR_WIDTH-1:0] post_q;

   logic [ADDR_WIDTH-1:0] ptr;
   logic [ADDR_WIDTH-1:0] post_cnt;
   logic                  prev_match;

   logic arm_accept;
   logic tick;
   logic match;
   logic trig_hit;
   logic post_last;

   // Arm is only honoured from a stopped capture; abort always takes priority.
   assign arm_accept = arm && !abort && ((cur_state == ST_IDLE) || (cur_state == ST_DONE));
   assign match      = ((sample_in ^ value_q) & mask_q) == '0;
   assign trig_hit   = tick && (cur_state == ST_ARMED) && match && (!edge_q || !prev_match);
   assign post_last  = tick && (cur_state == ST_POST) && (post_cnt == ADDR_WIDTH'(1));
   assign state      = cur_state;

   sample_rate_div #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_rate_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (arm_accept),
      .enable (is_capturing(cur_state)),
      .reload (div_q),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= ST_IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      if (abort) begin
         nxt_state = ST_IDLE;
      end else begin
         case (cur_state)
            ST_IDLE, ST_DONE: if (arm) nxt_state = ST_ARMED;
            ST_ARMED: begin
               if (trig_hit) nxt_state = (post_q == '0) ? ST_DONE : ST_POST;
            end
            ST_POST: if (post_last) nxt_state = ST_DONE;
            default: nxt_state = ST_IDLE;
         endcase
      end
   end

   // Config latch, write pointer, trigger bookkeeping and the registered RAM port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q      <= '0;
         value_q     <= '0;
         edge_q      <= 1'b0;
         div_q       <= '0;
         post_q      <= '0;
         ptr         <= '0;
         post_cnt    <= '0;
         prev_match  <= 1'b1;
         trig_addr   <= '0;
         wrapped     <= 1'b0;
         done        <= 1'b0;
         ram.wr_en   <= 1'b0;
         ram.wr_addr <= '0;
         ram.wr_data <= '0;
      end else begin
         ram.wr_en <= 1'b0;
         if (abort) begin
            done <= 1'b0;
         end else if (arm_accept) begin
            mask_q     <= trig_mask;
            value_q    <= trig_value;
            edge_q     <= trig_edge;
            div_q      <= rate_div;
            post_q     <= post_count;
            ptr        <= '0;
            post_cnt   <= '0;
            prev_match <= 1'b1;
            trig_addr  <= '0;
            wrapped    <= 1'b0;
            done       <= 1'b0;
         end else if (tick) begin
            ram.wr_en   <= 1'b1;
            ram.wr_addr <= ptr;
            ram.wr_data <= sample_in;
            ptr         <= ptr + ADDR_WIDTH'(1);
            if (cur_state == ST_ARMED) begin
               prev_match <= match;
               if (ptr == '1) wrapped <= 1'b1;
               if (trig_hit) begin
                  trig_addr <= ptr;
                  post_cnt  <= post_q;
                  if (post_q == '0) done <= 1'b1;
               end
            end else begin
               post_cnt <= post_cnt - ADDR_WIDTH'(1);
               if (post_cnt == ADDR_WIDTH'(1)) done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Directed bench for sample_capture_ctrl: expected RAM writes go into a
// scoreboard queue that a negedge monitor drains; status is checked directly.
module tb_sample_capture_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] sample_in;
   logic       arm;
   logic       abort;
   logic [7:0] trig_mask;
   logic [7:0] trig_value;
   logic       trig_edge;
   logic [15:0] rate_div;
   logic [9:0] post_count;
   logic [1:0] state;
   logic [9:0] trig_addr;
   logic       wrapped;
   logic       done;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [9:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t expQ[$];

   sample_capture_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) ram_bus ();

   sample_capture_ctrl #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (10),
      .DIV_WIDTH  (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_in  (sample_in),
      .arm        (arm),
      .abort      (abort),
      .trig_mask  (trig_mask),
      .trig_value (trig_value),
      .trig_edge  (trig_edge),
      .rate_div   (rate_div),
      .post_count (post_count),
      .ram        (ram_bus),
      .state      (state),
      .trig_addr  (trig_addr),
      .wrapped    (wrapped),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog");
   end

   // Monitor: every observed write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && ram_bus.wr_en) begin
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected write: got addr=0x%0h data=0x%0h, required none",
                     ram_bus.wr_addr, ram_bus.wr_data);
         end else begin
            wr_t e;
            e = expQ.pop_front();
            if (ram_bus.wr_addr !== e.addr || ram_bus.wr_data !== e.data) begin
               bad++;
               $display("[TB] FAIL ram write: got addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                        ram_bus.wr_addr, ram_bus.wr_data, e.addr, e.data);
            end
         end
      end
   end

   function automatic void expectWrite(input int addr, input int data);
      wr_t e;
      e.addr = addr[9:0];
      e.data = data[7:0];
      expQ.push_back(e);
   endfunction

   task automatic applyStimulus(input logic [7:0] s, input logic a, input logic ab);
      sample_in = s;
      arm       = a;
      abort     = ab;
      @(posedge clk);
      #1;
      arm   = 1'b0;
      abort = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic setConfig(input logic [7:0] m, input logic [7:0] v, input logic e,
                            input logic [15:0] d, input logic [9:0] p);
      trig_mask  = m;
      trig_value = v;
      trig_edge  = e;
      rate_div   = d;
      post_count = p;
   endtask

   task automatic drainCheck(input string name);
      applyStimulus(8'h00, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0);
      checkOutput(name, expQ.size(), 0);
   endtask

   logic [7:0] edgeSeq [9] = '{8'h05, 8'h15, 8'h25, 8'h35, 8'h55, 8'h03, 8'h45, 8'h46, 8'h47};

   initial begin
      rst_n = 1'b0;
      sample_in = '0;
      arm = 1'b0;
      abort = 1'b0;
      setConfig(8'h00, 8'h00, 1'b0, 16'd0, 10'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset state", state, 0);
      checkOutput("reset wr_en", ram_bus.wr_en, 0);
      checkOutput("reset done", done, 0);
      rst_n = 1'b1;
      applyStimulus(8'h00, 1'b0, 1'b0);
      checkOutput("idle state", state, 0);

      // Level trigger on a ramp, three post-trigger samples.
      $display("[TB] level trigger on ramp");
      setConfig(8'hFF, 8'h5A, 1'b0, 16'd0, 10'd3);
      for (int k = 0; k <= 'h5D; k++) expectWrite(k, k);
      applyStimulus(8'h00, 1'b1, 1'b0);
      checkOutput("armed state", state, 1);
      for (int k = 0; k <= 'h5D; k++) applyStimulus(8'(k), 1'b0, 1'b0);
      checkOutput("ramp done state", state, 3);
      checkOutput("ramp done flag", done, 1);
      checkOutput("ramp trig_addr", trig_addr, 'h5A);
      checkOutput("ramp wrapped", wrapped, 0);
      drainCheck("ramp queue drained");

      // Divider of 3 rearmed from DONE; ticks every 4th cycle.
      $display("[TB] rate divider 3");
      setConfig(8'hFF, 8'hEE, 1'b0, 16'd3, 10'd1);
      for (int j = 0; j < 5; j++) expectWrite(j, 12 * j + 4);
      applyStimulus(8'h00, 1'b1, 1'b0);
      for (int c = 1; c <= 20; c++) begin
         applyStimulus(8'(3 * c + 1), 1'b0, 1'b0);
         if (c == 1) checkOutput("div first wr_en", ram_bus.wr_en, 1);
         if (c == 2) checkOutput("div gap wr_en", ram_bus.wr_en, 0);
      end
      checkOutput("div armed state", state, 1);
      applyStimulus(8'h00, 1'b0, 1'b1);
      checkOutput("div abort state", state, 0);
      drainCheck("div queue drained");

      // Edge trigger needs a non-matching sample before the match.
      $display("[TB] edge trigger");
      setConfig(8'h0F, 8'h05, 1'b1, 16'd0, 10'd2);
      for (int k = 0; k < 9; k++) expectWrite(k, edgeSeq[k]);
      applyStimulus(8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 9; k++) begin
         applyStimulus(edgeSeq[k], 1'b0, 1'b0);
         if (k == 4) checkOutput("edge held match state", state, 1);
      end
      checkOutput("edge done state", state, 3);
      checkOutput("edge trig_addr", trig_addr, 6);
      checkOutput("edge done flag", done, 1);
      drainCheck("edge queue drained");

      // Long run without trigger: pointer wraps, config changes after arm ignored.
      $display("[TB] wrap without trigger");
      setConfig(8'h01, 8'h01, 1'b0, 16'd0, 10'd4);
      applyStimulus(8'h00, 1'b1, 1'b0);
      trig_mask = 8'h00;
      for (int k = 0; k < 1100; k++) begin
         expectWrite(k % 1024, k & 'hFE);
         applyStimulus(8'(k & 'hFE), k == 1050, 1'b0);
         if (k == 1022) checkOutput("wrapped before max", wrapped, 0);
         if (k == 1023) begin
            checkOutput("wrapped at max", wrapped, 1);
            checkOutput("max wr_addr", ram_bus.wr_addr, 1023);
         end
      end
      checkOutput("wrap armed state", state, 1);
      applyStimulus(8'h00, 1'b0, 1'b1);
      checkOutput("wrap abort state", state, 0);
      drainCheck("wrap queue drained");

      // Arm and abort together from IDLE: abort wins.
      applyStimulus(8'h00, 1'b1, 1'b1);
      checkOutput("arm+abort state", state, 0);
      drainCheck("arm+abort no writes");

      // post_count = 0 finishes on the trigger sample alone.
      $display("[TB] zero post count");
      setConfig(8'hFF, 8'h33, 1'b0, 16'd0, 10'd0);
      expectWrite(0, 'h10);
      expectWrite(1, 'h20);
      expectWrite(2, 'h33);
      applyStimulus(8'h00, 1'b1, 1'b0);
      applyStimulus(8'h10, 1'b0, 1'b0);
      applyStimulus(8'h20, 1'b0, 1'b0);
      applyStimulus(8'h33, 1'b0, 1'b0);
      checkOutput("post0 state", state, 3);
      checkOutput("post0 done", done, 1);
      checkOutput("post0 trig_addr", trig_addr, 2);
      checkOutput("post0 final wr_en", ram_bus.wr_en, 1);
      applyStimulus(8'h44, 1'b0, 1'b0);
      applyStimulus(8'h55, 1'b0, 1'b0);
      drainCheck("post0 queue drained");

      // Abort during POST suppresses the write of that tick.
      $display("[TB] abort in POST");
      setConfig(8'hFF, 8'h77, 1'b0, 16'd0, 10'd10);
      expectWrite(0, 'h70);
      expectWrite(1, 'h77);
      expectWrite(2, 'h78);
      expectWrite(3, 'h79);
      applyStimulus(8'h00, 1'b1, 1'b0);
      applyStimulus(8'h70, 1'b0, 1'b0);
      applyStimulus(8'h77, 1'b0, 1'b0);
      applyStimulus(8'h78, 1'b0, 1'b0);
      checkOutput("post state", state, 2);
      applyStimulus(8'h79, 1'b0, 1'b0);
      applyStimulus(8'h7A, 1'b0, 1'b1);
      checkOutput("post abort state", state, 0);
      checkOutput("post abort done", done, 0);
      drainCheck("post abort queue drained");

      // Asynchronous reset in POST clears everything immediately.
      $display("[TB] reset in POST");
      setConfig(8'hFF, 8'h42, 1'b0, 16'd0, 10'd5);
      expectWrite(0, 'h41);
      expectWrite(1, 'h42);
      applyStimulus(8'h00, 1'b1, 1'b0);
      applyStimulus(8'h41, 1'b0, 1'b0);
      applyStimulus(8'h42, 1'b0, 1'b0);
      applyStimulus(8'h43, 1'b0, 1'b0);
      checkOutput("pre-reset state", state, 2);
      checkOutput("pre-reset trig_addr", trig_addr, 1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset state", state, 0);
      checkOutput("async reset wr_en", ram_bus.wr_en, 0);
      checkOutput("async reset wr_addr", ram_bus.wr_addr, 0);
      checkOutput("async reset wr_data", ram_bus.wr_data, 0);
      checkOutput("async reset trig_addr", trig_addr, 0);
      checkOutput("async reset status", {wrapped, done}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drainCheck("reset queue drained");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
